// File: rtl/fir_serial_mac.sv
// fir_serial_mac: time-multiplexed single-multiplier FIR with run-time coefficients.
// Latency: sample accepted on cycle 0, MAC on cycles 1..N_TAPS, out_valid from cycle N_TAPS+1.
// Backpressure: in_ready_o is low while busy; result is held in OUT until out_ready_i.
//
// Ports:
//   clk, reset_n           rising-edge clock, synchronous active-low reset
//   in_valid_i/in_ready_o  sample handshake, in_data_i signed Q1.(DATA_W-1)
//   coef_we_i/coef_addr_i/coef_wdata_i  coefficient write (honoured in IDLE only)
//   out_valid_o/out_ready_i  result handshake, out_data_o signed Q1.(DATA_W-1)
//   busy_o                 high while in MAC or OUT
module fir_serial_mac #(
   parameter int N_TAPS  = 33,
   parameter int COEFF_W = 32,
   parameter int DATA_W  = 24,
   parameter int ADDR_W  = $clog2(N_TAPS)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic signed [DATA_W-1:0]  in_data_i,
   input  logic                      coef_we_i,
   input  logic [ADDR_W-1:0]         coef_addr_i,
   input  logic signed [COEFF_W-1:0] coef_wdata_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic signed [DATA_W-1:0]  out_data_o,
   output logic                      busy_o
);

   localparam int                ACC_W  = 2 * COEFF_W;
   localparam logic [ADDR_W:0]   NT     = (ADDR_W + 1)'(N_TAPS);
   localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_TAPS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic signed [COEFF_W-1:0] c_q [N_TAPS];
   logic signed [COEFF_W-1:0] x_q [N_TAPS];

   logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]       base_q, base_d;
   logic [ADDR_W-1:0]       k_q, k_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;

   logic                      accept;
   logic                      coef_wr;
   logic [ADDR_W-1:0]         rd_idx;
   logic [ADDR_W:0]           wrap_sum;
   logic signed [ACC_W-1:0]   prod;
   logic signed [COEFF_W-1:0] sample_aligned;

   // Sample occupies the top DATA_W bits so it shares the coefficient's Q1 scaling.
   assign sample_aligned = COEFF_W'(in_data_i) << (COEFF_W - DATA_W);

   // Top DATA_W bits of the accumulator are exactly acc >>> (ACC_W-DATA_W)
   // truncated to DATA_W; overflow wraps rather than saturates.
   assign out_data_o = acc_q[ACC_W-1 -: DATA_W];

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      busy_o      = 1'b0;
      accept      = 1'b0;
      coef_wr     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // A coefficient write wins the cycle; the sample waits.
            in_ready_o = !coef_we_i;
            coef_wr    = coef_we_i && ({1'b0, coef_addr_i} < NT);
            accept     = in_valid_i && !coef_we_i;
            if (accept) begin
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            busy_o = 1'b1;
            if (k_q == K_LAST) begin
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            busy_o      = 1'b1;
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------- datapath ----------------
   always_comb begin
      // Tap k multiplies the sample k positions older than the newest: (base - k) mod N.
      wrap_sum = NT + {1'b0, base_q} - {1'b0, k_q};
      if (base_q >= k_q) begin
         rd_idx = base_q - k_q;
      end else begin
         rd_idx = wrap_sum[ADDR_W-1:0];
      end
      prod = ACC_W'(x_q[rd_idx]) * ACC_W'(c_q[k_q]);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      base_d   = base_q;
      k_d      = k_q;
      acc_d    = acc_q;
      if (accept) begin
         base_d   = wr_ptr_q;
         wr_ptr_d = (wr_ptr_q == K_LAST) ? '0 : wr_ptr_q + 1'b1;
         k_d      = '0;
         acc_d    = '0;
      end else if (state_q == S_MAC) begin
         acc_d = acc_q + prod;
         k_d   = (k_q == K_LAST) ? '0 : k_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         base_q   <= '0;
         k_q      <= '0;
         acc_q    <= '0;
         for (int i = 0; i < N_TAPS; i++) begin
            c_q[i] <= '0;
            x_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         base_q   <= base_d;
         k_q      <= k_d;
         acc_q    <= acc_d;
         if (coef_wr) begin
            c_q[coef_addr_i] <= coef_wdata_i;
         end
         if (accept) begin
            x_q[wr_ptr_q] <= sample_aligned;
         end
      end
   end

endmodule

// File: doc/fir_serial_mac.md
# fir_serial_mac

Time-multiplexed, single-multiplier FIR filter with run-time-loadable coefficients. It is the streaming, handshaked counterpart of the team's fully parallel fixed-coefficient FIR. It accepts one sample per transaction over a valid/ready input, computes the N_TAPS-term convolution in N_TAPS MAC cycles, and presents the result over a valid/ready output. A host-side coefficient write port loads the tap weights.

## Interface
- N_TAPS, 33, number of taps (≥2).
- COEFF_W, 32, signed coefficient width, Q1.(COEFF_W-1).
- DATA_W, 24, signed sample width in/out, Q1.(DATA_W-1); COEFF_W ≥ DATA_W.
- ADDR_W, $clog2(N_TAPS), coefficient/tap index width.
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  DATA_W  signed input sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  ADDR_W  tap index to write.
- coef_wdata  in  COEFF_W  signed coefficient value.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_W  signed filtered sample.
- busy  out  1  high in MAC and OUT states.

## Operation
- Storage: N_TAPS×COEFF_W coefficient array c[k]; N_TAPS-entry circular sample buffer x (COEFF_W wide); write pointer wr_ptr; tap counter k; signed 2·COEFF_W accumulator acc.
- Sample alignment: stored value = {in_data, (COEFF_W-DATA_W) zeros}.
- FSM states:
  - IDLE: in_ready = !coef_we. On in_valid && in_ready, write the aligned sample at x[wr_ptr], latch base = wr_ptr, advance wr_ptr (N_TAPS-1 wraps to 0), clear acc, set k=0, go to MAC.
  - MAC: each cycle acc += x[(base-k) mod N_TAPS] * c[k], as a full signed 2·COEFF_W product. k increments each cycle. After k = N_TAPS-1 is accumulated, go to OUT.
  - OUT: out_valid=1, out_data = acc >>> (2·COEFF_W-DATA_W), truncated to DATA_W with no saturation. On out_ready, go to IDLE.
- Coefficient writes take effect only in IDLE. coef_we in IDLE has priority over a sample: in_ready is low that cycle. coef_we in MAC or OUT is ignored. coef_addr ≥ N_TAPS is ignored.
- Samples older than N_TAPS are overwritten (wrap). No flush is needed.
- Reset: c[k]=0, x[*]=0, wr_ptr=0, k=0, acc=0, state IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0.
- Acceptance edge is cycle 0. MAC runs in cycles 1..N_TAPS. out_valid rises in cycle N_TAPS+1. Latency is N_TAPS+1 cycles.
- out_valid and out_data hold stable while out_ready=0. While busy, in_ready=0.
- out_ready high in the first OUT cycle completes the transfer there. The next sample can be accepted on the following cycle.
- Throughput is one sample per N_TAPS+2 cycles.
- A reset asserted in any state, including mid-MAC or mid-OUT, takes effect at the next edge. The pending result is discarded and out_valid=0 on the next cycle.
- A coefficient written in IDLE at cycle t is used by a sample accepted at cycle t+1 or later.

## Test plan
- Single-tap impulse: write c[0]=0x40000000, all others 0. Feed 0x400000 → out_data=0x100000 at cycle 34. Then feed 0xC00000 → out_data=0xF00000.
- Tap ordering: write c[k]=0x40000000 for k=3 only. Feed 0x400000, then 0s → outputs 0,0,0,0x100000,0,… (sample 4 carries the response).
- Steady state and wrap: write all c[k]=0x40000000. Feed 40 samples of 0x040000 → output n equals n·0x10000 for n ≤ 33. Outputs 33..40 equal 0x210000.
- Backpressure: hold out_ready=0 for 10 cycles in OUT → out_valid=1, out_data constant, in_ready=0, busy=1. Release → IDLE on the next cycle.
- Coefficient priority and ignore: coef_we together with in_valid in IDLE → sample not taken (in_ready=0). coef_we during MAC → c unchanged, result matches the prior coefficients. coef_addr=33 → no effect.
- Reset mid-MAC: assert reset_n=0 at cycle 10 after acceptance → out_valid never asserted for that sample. After release, a re-fed impulse gives 0, because coefficients were cleared to 0.
